// File: rtl/tft_timing_gen.sv
// tft_timing_gen: parametrised TFT raster timing generator (x/y, DE, syncs, pixel/line/frame pulses, frame count)
module tft_timing_gen #(
  parameter int   H_ACTIVE  = 480,
  parameter int   H_FRONT   = 2,
  parameter int   H_SYNC    = 41,
  parameter int   H_BACK    = 2,
  parameter int   V_ACTIVE  = 272,
  parameter int   V_FRONT   = 2,
  parameter int   V_SYNC    = 10,
  parameter int   V_BACK    = 2,
  parameter int   CLK_DIV   = 1,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   X_W       = 10,
  parameter int   Y_W       = 9,
  parameter int   FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               restart,
  output logic [X_W-1:0]     tft_x,
  output logic [Y_W-1:0]     tft_y,
  output logic               tft_de,
  output logic               tft_hsync,
  output logic               tft_vsync,
  output logic               pixel_tick,
  output logic               tft_new_line,
  output logic               tft_new_frame,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]   X_MAX   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(V_TOTAL - 1);
  // One extra bit so window ends equal to 2^W do not wrap to zero
  localparam logic [X_W:0] X_DE  = (X_W+1)'(H_ACTIVE);
  localparam logic [X_W:0] X_HS0 = (X_W+1)'(H_ACTIVE + H_FRONT);
  localparam logic [X_W:0] X_HS1 = (X_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [Y_W:0] Y_DE  = (Y_W+1)'(V_ACTIVE);
  localparam logic [Y_W:0] Y_VS0 = (Y_W+1)'(V_ACTIVE + V_FRONT);
  localparam logic [Y_W:0] Y_VS1 = (Y_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  if (CLK_DIV < 1 || H_TOTAL > 2**X_W || V_TOTAL > 2**Y_W) begin : g_bad_params
    $error("tft_timing_gen: CLK_DIV must be >=1 and X_W/Y_W must hold H_TOTAL-1/V_TOTAL-1");
  end

  logic [DIV_W-1:0] r_div;
  logic             w_tick, w_go, w_xw, w_yw, w_nf;
  logic [X_W-1:0]   w_nx;
  logic [Y_W-1:0]   w_ny;
  logic [X_W:0]     w_nx1;
  logic [Y_W:0]     w_ny1;

  // Decode is taken from the next-state counters so every output refers to the same pixel
  assign w_tick = ena && r_div == DIV_MAX;
  assign w_go   = ena && (restart || w_tick);
  assign w_xw   = tft_x == X_MAX;
  assign w_yw   = tft_y == Y_MAX;
  assign w_nx   = (restart || w_xw) ? '0 : tft_x + X_W'(1);
  assign w_ny   = restart ? '0 : w_xw ? (w_yw ? '0 : tft_y + Y_W'(1)) : tft_y;
  assign w_nf   = w_nx == '0 && w_ny == '0;
  assign w_nx1  = {1'b0, w_nx};
  assign w_ny1  = {1'b0, w_ny};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      tft_x         <= X_MAX;
      tft_y         <= Y_MAX;
      tft_de        <= 1'b0;
      tft_hsync     <= ~HSYNC_POL;
      tft_vsync     <= ~VSYNC_POL;
      pixel_tick    <= 1'b0;
      tft_new_line  <= 1'b0;
      tft_new_frame <= 1'b0;
      frame_count   <= '1;
    end else begin
      pixel_tick    <= w_go;
      tft_new_line  <= w_go && w_nx == '0;
      tft_new_frame <= w_go && w_nf;
      if (ena) r_div <= (restart || w_tick) ? '0 : r_div + DIV_W'(1);
      if (w_go) begin
        tft_x       <= w_nx;
        tft_y       <= w_ny;
        tft_de      <= w_nx1 < X_DE && w_ny1 < Y_DE;
        tft_hsync   <= (w_nx1 >= X_HS0 && w_nx1 < X_HS1) ? HSYNC_POL : ~HSYNC_POL;
        tft_vsync   <= (w_ny1 >= Y_VS0 && w_ny1 < Y_VS1) ? VSYNC_POL : ~VSYNC_POL;
        frame_count <= frame_count + FRAME_W'(w_nf);
      end
    end
  end
endmodule

// File: tb/tb_tft_timing_gen.sv
// tb_tft_timing_gen: directed bench for tft_timing_gen; default panel timing plus a tiny
// CLK_DIV=4, positive-sync-polarity instance for whole-frame and divider behaviour.
module tb_tft_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, restart;
  logic [9:0]  d_x;
  logic [8:0]  d_y;
  logic        d_de, d_hs, d_vs, d_pt, d_nl, d_nf;
  logic [15:0] d_fc;

  logic        s_rst, s_ena, s_restart;
  logic [3:0]  s_x;
  logic [2:0]  s_y;
  logic        s_de, s_hs, s_vs, s_pt, s_nl, s_nf;
  logic [3:0]  s_fc;

  tft_timing_gen u_dut (
    .clk(clk), .rst(rst), .ena(ena), .restart(restart),
    .tft_x(d_x), .tft_y(d_y), .tft_de(d_de), .tft_hsync(d_hs), .tft_vsync(d_vs),
    .pixel_tick(d_pt), .tft_new_line(d_nl), .tft_new_frame(d_nf), .frame_count(d_fc)
  );

  // 10 x 8 raster: de x<6,y<4; hsync x 7..8; vsync y 5..6; 80 pixels = 320 clks per frame
  tft_timing_gen #(
    .H_ACTIVE(6), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(4), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .X_W(4), .Y_W(3), .FRAME_W(4)
  ) u_small (
    .clk(clk), .rst(s_rst), .ena(s_ena), .restart(s_restart),
    .tft_x(s_x), .tft_y(s_y), .tft_de(s_de), .tft_hsync(s_hs), .tft_vsync(s_vs),
    .pixel_tick(s_pt), .tft_new_line(s_nl), .tft_new_frame(s_nf), .frame_count(s_fc)
  );

  int          n_chk = 0, n_err = 0;
  int          mx, my, sx, sy, sdiv;
  logic [15:0] mfc;
  logic [3:0]  sfc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic d_chk_all(input bit p);
    chk("d_x", d_x, mx);
    chk("d_y", d_y, my);
    chk("d_de", d_de, mx < 480 && my < 272);
    chk("d_hsync", d_hs, !(mx >= 482 && mx <= 522));
    chk("d_vsync", d_vs, !(my >= 274 && my <= 283));
    chk("d_pixel_tick", d_pt, p);
    chk("d_new_line", d_nl, p && mx == 0);
    chk("d_new_frame", d_nf, p && mx == 0 && my == 0);
    chk("d_frame_count", d_fc, mfc);
  endtask

  task automatic d_step();
    @(negedge clk);
    mx++;
    if (mx == 525) begin
      mx = 0;
      my++;
      if (my == 286) begin
        my = 0;
        mfc++;
      end
    end
    d_chk_all(1'b1);
  endtask

  task automatic s_chk_all(input bit p);
    chk("s_x", s_x, sx);
    chk("s_y", s_y, sy);
    chk("s_de", s_de, sx < 6 && sy < 4);
    chk("s_hsync", s_hs, sx >= 7 && sx <= 8);
    chk("s_vsync", s_vs, sy >= 5 && sy <= 6);
    chk("s_pixel_tick", s_pt, p);
    chk("s_new_line", s_nl, p && sx == 0);
    chk("s_new_frame", s_nf, p && sx == 0 && sy == 0);
    chk("s_frame_count", s_fc, sfc);
  endtask

  task automatic s_clk();
    bit p;
    @(negedge clk);
    p = 1'b0;
    if (s_ena && s_restart) begin
      sdiv = 0; sx = 0; sy = 0; sfc++; p = 1'b1;
    end else if (s_ena && sdiv == 3) begin
      sdiv = 0; p = 1'b1; sx++;
      if (sx == 10) begin
        sx = 0; sy++;
        if (sy == 8) begin sy = 0; sfc++; end
      end
    end else if (s_ena) sdiv++;
    s_chk_all(p);
  endtask

  initial begin
    int last, cyc, nfr;
    logic [15:0] fc_before;
    rst = 1'b1; ena = 1'b0; restart = 1'b0;
    s_rst = 1'b1; s_ena = 1'b0; s_restart = 1'b0;
    mx = 524; my = 285; mfc = 16'hffff;
    repeat (3) @(negedge clk);
    d_chk_all(1'b0);
    rst = 1'b0; ena = 1'b1;
    d_chk_all(1'b0);
    d_step();
    chk("first_pixel_de", d_de, 1'b1);
    repeat (479) d_step();
    chk("x479_de", d_de, 1'b1);
    d_step();
    chk("x480_de", d_de, 1'b0);
    repeat (45) d_step();
    chk("line_wrap_y", d_y, 9'd1);
    chk("line_wrap_nl", d_nl, 1'b1);
    while (!(mx == 100 && my == 10)) d_step();
    ena = 1'b0;
    repeat (7) begin
      @(negedge clk);
      d_chk_all(1'b0);
    end
    ena = 1'b1;
    d_step();
    chk("resume_x", d_x, 10'd101);
    while (!(mx == 300 && my == 50)) d_step();
    fc_before = d_fc;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    mx = 0; my = 0; mfc++;
    d_chk_all(1'b1);
    chk("restart_fc", d_fc, fc_before + 16'd1);
    while (mx != 200) d_step();
    rst = 1'b1;
    #1;
    mx = 524; my = 285; mfc = 16'hffff;
    d_chk_all(1'b0);
    @(negedge clk);
    d_chk_all(1'b0);
    rst = 1'b0;
    d_step();
    chk("post_rst_fc", d_fc, 16'd0);

    sx = 9; sy = 7; sdiv = 0; sfc = 4'hf;
    s_chk_all(1'b0);
    s_rst = 1'b0; s_ena = 1'b1;
    last = -1; cyc = 0; nfr = 0;
    repeat (650) begin
      s_clk();
      cyc++;
      if (s_nf) begin
        if (last >= 0) chk("s_frame_gap", cyc - last, 320);
        last = cyc;
        nfr++;
      end
    end
    chk("s_frames_seen", nfr, 3);
    chk("s_fc_after_2", s_fc, 4'd2);
    while (!(sx == 9 && sy == 7 && sdiv == 3)) s_clk();
    s_restart = 1'b1;
    s_clk();
    s_restart = 1'b0;
    chk("s_restart_last_fc", s_fc, 4'd3);
    repeat (5) s_clk();
    chk("s_restart_hold_x", s_x, 4'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
